quant_zigzag: RTL and testbench

QUANT_ZIGZAG -- requirements
Module: quant_zigzag

---
 rtl/quant_zigzag.sv | 158 +++++++++++++++
 tb/tb_quant_zigzag.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quant_zigzag.sv
// quant_zigzag: ping-pong 8x8 coefficient buffer, zigzag readout and JPEG Q50 luminance quantization.
// Define QUANT_ROUND_EN to round half away from zero; by default the quotient truncates toward zero.
module quant_zigzag #(
  parameter int unsigned OUT_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic signed [15:0]      dct_in,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    q_valid,
  output logic                    q_last,
  output logic                    block_done,
  output logic                    overflow
);

  localparam int unsigned IN_W    = 16;
  localparam int unsigned AW      = 6;
  localparam int unsigned NCOEF   = 64;
  localparam int unsigned R_W     = 17;
  localparam int unsigned P_W     = IN_W + R_W;
  localparam int unsigned QM_W    = P_W - 16;
  localparam int unsigned POS_LIM = (1 << (OUT_W - 1)) - 1;

  localparam int unsigned ZZ [NCOEF] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  localparam int unsigned QT [NCOEF] = '{
    16, 11, 10, 16, 24, 40, 51, 61,  12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,  14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68,109,103, 77,  24, 35, 55, 64, 81,104,113, 92,
    49, 64, 78, 87,103,121,120,101,  72, 92, 95, 98,112,100,103, 99};

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t           state;
  logic [1:0]       full;
  logic             wbank, rbank;
  logic [AW-1:0]    waddr, raddr;
  logic [IN_W-1:0]  mem [2][NCOEF];
  logic [AW-1:0]    zz_rom [NCOEF];
  logic [R_W-1:0]   r_rom [NCOEF];

  logic             rd_start, rd_end, wr_ok, wr_fire, wr_fill;
  logic [1:0]       rel_mask, fill_mask;

  logic             s1_valid, s1_last;
  logic [IN_W-1:0]  s1_coef;
  logic [R_W-1:0]   s1_r;

  logic [IN_W-1:0]         mag_c;
  logic [P_W-1:0]          prod_c;
  logic [QM_W-1:0]         qmag_c;
  logic signed [OUT_W-1:0] qsat_c;

  // Reciprocal table R = round(65536/Q) folded to constants at elaboration.
  for (genvar i = 0; i < NCOEF; i++) begin : g_rom
    assign zz_rom[i] = AW'(ZZ[i]);
    assign r_rom[i]  = R_W'((32'd65536 + QT[i] / 2) / QT[i]);
  end

  assign rd_start  = full[rbank];
  assign rd_end    = (state == DRAIN) && (raddr == AW'(NCOEF - 1));
  // A bank being released this cycle is already writable.
  assign wr_ok     = !full[wbank] || (rd_end && (rbank == wbank));
  assign wr_fire   = valid_in && wr_ok;
  assign wr_fill   = wr_fire && (waddr == AW'(NCOEF - 1));
  assign rel_mask  = {rd_end & rbank, rd_end & ~rbank};
  assign fill_mask = {wr_fill & wbank, wr_fill & ~wbank};

  // Write side: bank fill, bank swap, full flags and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank    <= 1'b0;
      waddr    <= '0;
      full     <= 2'b00;
      overflow <= 1'b0;
    end else begin
      full <= (full & ~rel_mask) | fill_mask;
      if (wr_fire) begin
        waddr <= waddr + AW'(1);
        if (wr_fill) wbank <= ~wbank;
      end
      if (valid_in && !wr_ok) overflow <= 1'b1;
    end
  end

  // Sample storage and stage-1 read data; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wbank][waddr] <= dct_in;
    s1_coef <= mem[rbank][zz_rom[raddr]];
    s1_r    <= r_rom[zz_rom[raddr]];
  end

  // Read FSM issuing one zigzag address per cycle, chaining banks without a gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rbank    <= 1'b0;
      raddr    <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= (state == DRAIN);
      s1_last  <= rd_end;
      case (state)
        IDLE: begin
          raddr <= '0;
          if (rd_start) state <= DRAIN;
        end
        DRAIN: begin
          raddr <= raddr + AW'(1);
          if (rd_end) begin
            rbank <= ~rbank;
            if (!full[~rbank]) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sign-magnitude multiply by reciprocal, optional rounding, then saturation.
  always_comb begin
    mag_c  = s1_coef[IN_W-1] ? (~s1_coef + IN_W'(1)) : s1_coef;
    prod_c = P_W'(mag_c) * P_W'(s1_r);
`ifdef QUANT_ROUND_EN
    prod_c = prod_c + P_W'(1 << 15);
`endif
    qmag_c = QM_W'(prod_c >> 16);
    if (s1_coef[IN_W-1]) begin
      if (qmag_c > QM_W'(POS_LIM + 1)) qsat_c = {1'b1, {(OUT_W-1){1'b0}}};
      else                             qsat_c = OUT_W'(~qmag_c + QM_W'(1));
    end else if (qmag_c > QM_W'(POS_LIM)) begin
      qsat_c = {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      qsat_c = OUT_W'(qmag_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_out      <= '0;
      q_valid    <= 1'b0;
      q_last     <= 1'b0;
      block_done <= 1'b0;
    end else begin
      q_out      <= s1_valid ? qsat_c : '0;
      q_valid    <= s1_valid;
      q_last     <= s1_last;
      block_done <= s1_last;
    end
  end

endmodule

// File: tb/tb_quant_zigzag.sv
// Self-checking bench for quant_zigzag: directed block table, random blocks vs a reference model,
// back-to-back streaming, mid-block reset and forced-stall overflow sequences.
module tb_quant_zigzag;

  localparam int OUT_W = 12;
  localparam int SMAX  = (1 << (OUT_W - 1)) - 1;
  localparam int SMIN  = -(1 << (OUT_W - 1));

  logic                    clk, rst_n, valid_in;
  logic signed [15:0]      dct_in;
  logic signed [OUT_W-1:0] q_out;
  logic                    q_valid, q_last, block_done, overflow;

  quant_zigzag #(.OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .dct_in(dct_in),
    .q_out(q_out), .q_valid(q_valid), .q_last(q_last),
    .block_done(block_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int val; bit last; } exp_t;
  typedef struct { int idx; int val; int exp; } vec_t;

  int   n_checks = 0, n_errors = 0;
  int   n_done = 0, run_len = 0, max_run = 0;
  exp_t exp_q [$];
  int   zz [64];
  int   qtab [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,  12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,  14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68,109,103, 77,  24, 35, 55, 64, 81,104,113, 92,
    49, 64, 78, 87,103,121,120,101,  72, 92, 95, 98,112,100,103, 99};

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Zigzag order by walking anti-diagonals, alternating direction.
  function automatic void build_zz();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin zz[n] = r * 8 + (s - r); n++; end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin zz[n] = r * 8 + (s - r); n++; end
      end
    end
  endfunction

  function automatic int quant(input int c, input int q);
    int r, mag, res;
    longint p;
    r   = (65536 + q / 2) / q;
    mag = (c < 0) ? -c : c;
    p   = longint'(mag) * r;
`ifdef QUANT_ROUND_EN
    p   = p + 32768;
`endif
    res = int'(p / 65536);
    if (c < 0) res = -res;
    if (res > SMAX) res = SMAX;
    if (res < SMIN) res = SMIN;
    return res;
  endfunction

  task automatic push_model(input int blk[64]);
    exp_t e;
    for (int k = 0; k < 64; k++) begin
      e.val = quant(blk[zz[k]], qtab[zz[k]]);
      e.last = (k == 63);
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_block(output int blk[64]);
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 3))
        0:       blk[i] = int'($signed(16'($urandom)));
        1:       blk[i] = 0;
        default: blk[i] = int'($urandom_range(0, 4000)) - 2000;
      endcase
    end
  endtask

  task automatic send_block(input int blk[64], input bit gaps);
    for (int i = 0; i < 64; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin valid_in = 1'b0; @(posedge clk); #1; end
      end
      valid_in = 1'b1;
      dct_in   = 16'(blk[i]);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || q_valid) && cyc < 1000) begin @(negedge clk); cyc++; end
    chk("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_q_out"}, int'(q_out), 0);
    chk({tag, "_q_valid"}, int'(q_valid), 0);
    chk({tag, "_q_last"}, int'(q_last), 0);
    chk({tag, "_block_done"}, int'(block_done), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask

  // Output monitor: every valid output is compared with the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (block_done) n_done++;
    if (q_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_q_valid: got q_out=%0d with no expected output (t=%0t)", q_out, $time);
      end else begin
        e = exp_q.pop_front();
        chk("q_out", int'(q_out), e.val);
        chk("q_last", int'(q_last), int'(e.last));
        chk("block_done", int'(block_done), int'(e.last));
      end
    end else begin
      run_len = 0;
      chk("stray_pulse", int'(q_last | block_done), 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    vec_t vecs [9];
    int   blk [64], b0 [64], b1 [64], b2 [64];
    int   done0, kpos;
    exp_t e;

    build_zz();
    vecs[0] = '{0, 1024, 64};
    vecs[1] = '{1, 110, 10};
`ifdef QUANT_ROUND_EN
    vecs[2] = '{8, -120, -10};
    vecs[3] = '{0, -25, -2};
    vecs[4] = '{2, 5, 1};
`else
    vecs[2] = '{8, -120, -9};
    vecs[3] = '{0, -25, -1};
    vecs[4] = '{2, 5, 0};
`endif
    vecs[5] = '{0, 32767, 2047};
    vecs[6] = '{0, -32768, -2048};
    vecs[7] = '{63, -1000, -10};
    vecs[8] = '{5, 300, 7};

    clk = 1'b0; rst_n = 1'b0; valid_in = 1'b0; dct_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst_n = 1'b1;

    // Directed single-coefficient blocks.
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 64; i++) blk[i] = 0;
      blk[vecs[v].idx] = vecs[v].val;
      kpos = 0;
      for (int k = 0; k < 64; k++) if (zz[k] == vecs[v].idx) kpos = k;
      for (int k = 0; k < 64; k++) begin
        e.val = (k == kpos) ? vecs[v].exp : 0;
        e.last = (k == 63);
        exp_q.push_back(e);
      end
      send_block(blk, 1'b0);
      wait_drain();
    end

    // Three back-to-back random blocks on a continuous input stream.
    max_run = 0; done0 = n_done;
    rand_block(b0); rand_block(b1); rand_block(b2);
    push_model(b0); push_model(b1); push_model(b2);
    send_block(b0, 1'b0); send_block(b1, 1'b0); send_block(b2, 1'b0);
    wait_drain();
    chk("contig_valid_run", max_run, 192);
    chk("block_done_count", n_done - done0, 3);
    chk("overflow_stream", int'(overflow), 0);

    // Random blocks with idle gaps in valid_in.
    for (int n = 0; n < 3; n++) begin
      rand_block(blk); push_model(blk); send_block(blk, 1'b1);
    end
    wait_drain();

    // Reset in the middle of block 2 while block 1 is draining.
    rand_block(b0); rand_block(b1);
    push_model(b0);
    send_block(b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      valid_in = 1'b1; dct_in = 16'(b1[i]); @(posedge clk); #1;
    end
    chk("midreset_active", int'(q_valid), 1);
    rst_n = 1'b0; valid_in = 1'b0;
    #1;
    chk_reset_outs("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rand_block(blk); push_model(blk); send_block(blk, 1'b0);
    wait_drain();

    // Hold the read FSM idle so a third block hits two full banks.
    force dut.rd_start = 1'b0;
    rand_block(b0); rand_block(b1); rand_block(b2);
    push_model(b0); push_model(b1);
    send_block(b0, 1'b0); send_block(b1, 1'b0); send_block(b2, 1'b0);
    chk("overflow_set", int'(overflow), 1);
    chk("held_no_output", int'(q_valid), 0);
    release dut.rd_start;
    wait_drain();
    chk("overflow_sticky", int'(overflow), 1);
    rst_n = 1'b0;
    #1;
    chk("overflow_reset", int'(overflow), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
